// File: rtl/atid_alloc_arbiter.sv
// ATB trace-ID allocator: round-robin arbitration among sources, next-fit cursor
// over the legal ATID sequence, skipping IDs currently bound to another source.
module atid_alloc_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NUM_SRC-1:0]     req,
    input  logic [NUM_SRC-1:0]     rel,
    output logic [NUM_SRC-1:0]     src_bound,
    output logic [NUM_SRC*8-1:0]   src_atid,
    output logic                   gnt_valid,
    output logic [SRC_W-1:0]       gnt_src,
    output logic [7:0]             gnt_atid,
    output logic                   busy
);

    typedef enum logic {IDLE, SEARCH} state_t;

    state_t               state_q, state_d;
    logic [7:0]           cursor_q, cursor_d;
    logic [SRC_W-1:0]     rr_q, rr_d;
    logic [SRC_W-1:0]     win_q, win_d;
    logic [NUM_SRC-1:0]   bound_q, bound_d;
    logic [7:0]           atid_q [NUM_SRC];
    logic [7:0]           atid_d [NUM_SRC];
    logic                 gv_q, gv_d;
    logic [SRC_W-1:0]     gs_q, gs_d;
    logic [7:0]           ga_q, ga_d;

    logic [NUM_SRC-1:0]   elig;
    logic                 found;
    logic [SRC_W-1:0]     pick;
    logic                 cur_free;

    // 0x70..0x7F is reserved and 0x00 means "no ID", so the cursor jumps over them.
    function automatic logic [7:0] next_id(input logic [7:0] c);
        if (c == 8'h6F)      return 8'h80;
        else if (c == 8'hFF) return 8'h01;
        else                 return c + 8'h01;
    endfunction

    function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] a, input int k);
        int s;
        s = int'(a) + k;
        if (s >= NUM_SRC) s = s - NUM_SRC;
        return SRC_W'(s);
    endfunction

    always_comb begin
        elig  = req & ~bound_q;
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!found && elig[wrap_add(rr_q, k)]) begin
                found = 1'b1;
                pick  = wrap_add(rr_q, k);
            end
        end
    end

    always_comb begin
        cur_free = 1'b1;
        for (int j = 0; j < NUM_SRC; j++) begin
            if (bound_q[j] && (atid_q[j] == cursor_q)) cur_free = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        rr_d     = rr_q;
        win_d    = win_q;
        bound_d  = bound_q;
        atid_d   = atid_q;
        gv_d     = 1'b0;
        gs_d     = gs_q;
        ga_d     = ga_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    win_d   = pick;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                cursor_d = next_id(cursor_q);
                if (cur_free) begin
                    atid_d[win_q]  = cursor_q;
                    bound_d[win_q] = 1'b1;
                    gv_d           = 1'b1;
                    gs_d           = win_q;
                    ga_d           = cursor_q;
                    rr_d           = wrap_add(win_q, 1);
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // The winner is unbound, so a release never collides with the grant write.
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rel[i] && bound_q[i]) begin
                bound_d[i] = 1'b0;
                atid_d[i]  = 8'h00;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cursor_q <= 8'h01;
            rr_q     <= '0;
            win_q    <= '0;
            bound_q  <= '0;
            gv_q     <= 1'b0;
            gs_q     <= '0;
            ga_q     <= 8'h00;
            for (int i = 0; i < NUM_SRC; i++) atid_q[i] <= 8'h00;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            rr_q     <= rr_d;
            win_q    <= win_d;
            bound_q  <= bound_d;
            gv_q     <= gv_d;
            gs_q     <= gs_d;
            ga_q     <= ga_d;
            for (int i = 0; i < NUM_SRC; i++) atid_q[i] <= atid_d[i];
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_atid
        assign src_atid[8*g +: 8] = atid_q[g];
    end

    assign src_bound = bound_q;
    assign gnt_valid = gv_q;
    assign gnt_src   = gs_q;
    assign gnt_atid  = ga_q;
    assign busy      = (state_q == SEARCH);

endmodule

// File: tb/tb_atid_alloc_arbiter.sv
// Randomized and directed bench for atid_alloc_arbiter against a list-based
// reference model of the allocation rules.
module tb_atid_alloc_arbiter;

    localparam int NUM = 4;
    localparam int SW  = 2;

    logic             clk = 1'b0;
    logic             rstn_r;
    logic [NUM-1:0]   req_r;
    logic [NUM-1:0]   rel_r;
    logic [NUM-1:0]   src_bound;
    logic [NUM*8-1:0] src_atid;
    logic             gnt_valid;
    logic [SW-1:0]    gnt_src;
    logic [7:0]       gnt_atid;
    logic             busy;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: cursor is an index into the list of grantable IDs.
    int seq[$];
    int m_cur, m_rr, m_pend, m_gs, m_ga;
    bit m_gv;
    int m_id  [NUM];
    bit m_bnd [NUM];

    atid_alloc_arbiter #(.NUM_SRC(NUM), .SRC_W(SW)) dut (
        .clk       (clk),
        .resetn    (rstn_r),
        .req       (req_r),
        .rel       (rel_r),
        .src_bound (src_bound),
        .src_atid  (src_atid),
        .gnt_valid (gnt_valid),
        .gnt_src   (gnt_src),
        .gnt_atid  (gnt_atid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_in_use(input int id);
        for (int j = 0; j < NUM; j++) if (m_bnd[j] && m_id[j] == id) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_edge();
        int n_id [NUM];
        bit n_bnd [NUM];
        int n_pend;
        n_id   = m_id;
        n_bnd  = m_bnd;
        n_pend = m_pend;
        m_gv   = 1'b0;
        if (!rstn_r) begin
            for (int i = 0; i < NUM; i++) begin n_id[i] = 0; n_bnd[i] = 0; end
            m_cur = 0; m_rr = 0; n_pend = -1; m_gs = 0; m_ga = 0;
        end else begin
            if (m_pend < 0) begin
                for (int k = 0; k < NUM; k++) begin
                    if (n_pend < 0 && req_r[(m_rr + k) % NUM] && !m_bnd[(m_rr + k) % NUM])
                        n_pend = (m_rr + k) % NUM;
                end
            end else begin
                if (!m_in_use(seq[m_cur])) begin
                    n_id[m_pend]  = seq[m_cur];
                    n_bnd[m_pend] = 1'b1;
                    m_gv = 1'b1;
                    m_gs = m_pend;
                    m_ga = seq[m_cur];
                    m_rr = (m_pend + 1) % NUM;
                    n_pend = -1;
                end
                m_cur = (m_cur + 1) % seq.size();
            end
            for (int i = 0; i < NUM; i++) begin
                if (rel_r[i] && m_bnd[i]) begin n_bnd[i] = 1'b0; n_id[i] = 0; end
            end
        end
        m_id   = n_id;
        m_bnd  = n_bnd;
        m_pend = n_pend;
    endtask

    task automatic compare_all();
        logic [NUM*8-1:0] e_atid;
        logic [NUM-1:0]   e_bnd;
        bit bad;
        for (int i = 0; i < NUM; i++) begin
            e_atid[8*i +: 8] = 8'(m_id[i]);
            e_bnd[i]         = m_bnd[i];
        end
        chk("gnt_valid", gnt_valid, m_gv);
        chk("gnt_src",   gnt_src,   m_gs);
        chk("gnt_atid",  gnt_atid,  m_ga);
        chk("busy",      busy,      m_pend >= 0);
        chk("src_bound", src_bound, e_bnd);
        chk("src_atid",  src_atid,  e_atid);
        bad = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            if (src_bound[i] && (src_atid[8*i +: 8] == 8'h00 ||
                (src_atid[8*i +: 8] >= 8'h70 && src_atid[8*i +: 8] <= 8'h7F))) bad = 1'b1;
            for (int j = i + 1; j < NUM; j++)
                if (src_bound[i] && src_bound[j] && src_atid[8*i +: 8] == src_atid[8*j +: 8]) bad = 1'b1;
        end
        chk("invariant", bad, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rstn_r = 1'b0; req_r = '0; rel_r = '0;
        step();
        rstn_r = 1'b1;
    endtask

    task automatic alloc(input int s, input bit do_rel, output int got);
        got = -1;
        req_r[s] = 1'b1;
        for (int k = 0; k < 20 && got < 0; k++) begin
            step();
            if (gnt_valid && gnt_src == s) got = gnt_atid;
        end
        req_r[s] = 1'b0;
        if (got < 0) chk("alloc_timeout", 0, 1);
        if (do_rel) begin
            rel_r[s] = 1'b1;
            step();
            rel_r[s] = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got, gcnt, last, nb;
        for (int v = 1; v < 256; v++) if (v < 'h70 || v > 'h7F) seq.push_back(v);
        m_cur = 0; m_rr = 0; m_pend = -1; m_gv = 0; m_gs = 0; m_ga = 0;
        for (int i = 0; i < NUM; i++) begin m_id[i] = 0; m_bnd[i] = 0; end
        rstn_r = 1'b0; req_r = '0; rel_r = '0;

        // Reset state and single request
        do_reset();
        chk("rst_bound", src_bound, 4'b0000);
        req_r = 4'b0100;
        step();
        chk("single_busy", busy, 1'b1);
        chk("single_nogv", gnt_valid, 1'b0);
        req_r = '0;
        step();
        chk("single_gv", gnt_valid, 1'b1);
        chk("single_src", gnt_src, 2);
        chk("single_atid", gnt_atid, 8'h01);
        chk("single_bound", src_bound, 4'b0100);
        chk("single_atid2", src_atid[23:16], 8'h01);
        step();
        chk("single_pulse", gnt_valid, 1'b0);

        // All-request round robin, then overlap of release and request
        do_reset();
        req_r = 4'b1111;
        gcnt = 0; last = 0;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (gnt_valid) begin
                chk("rr_src", gnt_src, gcnt);
                chk("rr_atid", gnt_atid, gcnt + 1);
                if (gcnt > 0) chk("rr_spacing", k - last, 2);
                last = k;
                gcnt++;
            end
        end
        chk("rr_count", gcnt, 4);
        req_r = 4'b1000;
        rel_r = 4'b1000;
        step();
        rel_r = '0;
        chk("ovl_bound3", src_bound[3], 1'b0);
        chk("ovl_atid3", src_atid[31:24], 8'h00);
        alloc(3, 1'b0, got);
        chk("ovl_regrant", got, 8'h05);

        // Reserved-range skip
        do_reset();
        for (int r = 0; r < 110; r++) alloc(0, 1'b1, got);
        alloc(0, 1'b1, got);
        chk("skip_6f", got, 8'h6F);
        alloc(0, 1'b1, got);
        chk("skip_80", got, 8'h80);

        // Wrap with collision on 0x01
        do_reset();
        alloc(1, 1'b0, got);
        chk("wrap_hold01", got, 8'h01);
        for (int r = 0; r < 300 && got != 255; r++) alloc(0, 1'b1, got);
        chk("wrap_reach_ff", got, 8'hFF);
        req_r[0] = 1'b1;
        nb = 0; got = -1;
        for (int k = 0; k < 20 && got < 0; k++) begin
            step();
            if (busy) nb++;
            if (gnt_valid) got = gnt_atid;
        end
        req_r[0] = 1'b0;
        chk("wrap_grant", got, 8'h02);
        chk("wrap_busy", nb, 2);

        // Reset during SEARCH
        do_reset();
        req_r[0] = 1'b1;
        step();
        chk("mid_busy", busy, 1'b1);
        rstn_r = 1'b0;
        step();
        chk("mid_nogv", gnt_valid, 1'b0);
        chk("mid_bound", src_bound, 4'b0000);
        chk("mid_busy0", busy, 1'b0);
        rstn_r = 1'b1;
        alloc(0, 1'b0, got);
        chk("mid_regrant", got, 8'h01);

        // Randomized traffic with occasional reset
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            req_r  = 4'($urandom_range(0, 15));
            rel_r  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            rstn_r = ($urandom_range(0, 299) != 0);
            step();
        end
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
